// File: rtl/matrix_mult_dot_accumulator.sv
// Dot-product accumulator behind the MatrixMult multiplier: sums K_LEN products per result and
// presents each result on a valid/ready register with saturation and framing-error flags.
module matrix_mult_dot_accumulator #(
  parameter int unsigned PROD_WIDTH = 30,
  parameter int unsigned ACC_WIDTH  = 34,
  parameter int unsigned K_LEN      = 16,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic [PROD_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic                  out_ovf,
  input  logic                  out_ready
);

  localparam logic [CNT_WIDTH-1:0] LastCnt = CNT_WIDTH'(K_LEN - 1);
  localparam logic [ACC_WIDTH-1:0] AccMax  = '1;

  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_err_q, out_err_d;
  logic                 out_ovf_q, out_ovf_d;

  logic                 accept, xfer, last_term, term, ovf_beat;
  logic [ACC_WIDTH-1:0] base, sum;
  logic [ACC_WIDTH:0]   sum_wide;

  assign in_ready  = ce & ~reset & (~out_valid_q | out_ready);
  assign accept    = in_valid & in_ready;
  assign xfer      = ce & out_valid_q & out_ready;
  assign last_term = (cnt_q == LastCnt);
  assign term      = last_term | in_last;

  // A fresh dot product ignores whatever acc holds; the carry bit flags saturation.
  assign base     = (cnt_q == '0) ? '0 : acc_q;
  assign sum_wide = {1'b0, base} + (ACC_WIDTH + 1)'(in_data);
  assign ovf_beat = sum_wide[ACC_WIDTH];
  assign sum      = ovf_beat ? AccMax : sum_wide[ACC_WIDTH-1:0];

  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_ovf_d   = out_ovf_q;
    if (xfer) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (term) begin
        out_data_d  = sum;
        out_valid_d = 1'b1;
        out_err_d   = in_last != last_term;
        out_ovf_d   = ovf_q | ovf_beat;
        acc_d       = '0;
        cnt_d       = '0;
        ovf_d       = 1'b0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
        ovf_d = ovf_q | ovf_beat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else if (ce) begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_err   = out_err_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_matrix_mult_dot_accumulator.sv
// Bench for matrix_mult_dot_accumulator: four parameterisations share one stimulus bus and are
// exercised one at a time through a vector table plus hand-written handshake sequences.
module tb_matrix_mult_dot_accumulator;

  logic        clk = 1'b0;
  logic        reset, ce, in_last, out_ready;
  logic [29:0] in_data;
  logic [3:0]  vld, ir, ov, oe, oo;
  logic [33:0] od0, od1, od3;
  logic [30:0] od2;
  logic [33:0] od [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign od[0] = od0;
  assign od[1] = od1;
  assign od[2] = {3'b000, od2};
  assign od[3] = od3;

  // 0: K_LEN=4, 1: defaults, 2: ACC_WIDTH=31 K_LEN=4, 3: K_LEN=2
  matrix_mult_dot_accumulator #(.K_LEN(4)) u_k4 (
    .clk(clk), .reset(reset), .ce(ce), .in_data(in_data), .in_valid(vld[0]), .in_last(in_last),
    .in_ready(ir[0]), .out_data(od0), .out_valid(ov[0]), .out_err(oe[0]), .out_ovf(oo[0]),
    .out_ready(out_ready)
  );
  matrix_mult_dot_accumulator u_def (
    .clk(clk), .reset(reset), .ce(ce), .in_data(in_data), .in_valid(vld[1]), .in_last(in_last),
    .in_ready(ir[1]), .out_data(od1), .out_valid(ov[1]), .out_err(oe[1]), .out_ovf(oo[1]),
    .out_ready(out_ready)
  );
  matrix_mult_dot_accumulator #(.ACC_WIDTH(31), .K_LEN(4)) u_a31 (
    .clk(clk), .reset(reset), .ce(ce), .in_data(in_data), .in_valid(vld[2]), .in_last(in_last),
    .in_ready(ir[2]), .out_data(od2), .out_valid(ov[2]), .out_err(oe[2]), .out_ovf(oo[2]),
    .out_ready(out_ready)
  );
  matrix_mult_dot_accumulator #(.K_LEN(2)) u_k2 (
    .clk(clk), .reset(reset), .ce(ce), .in_data(in_data), .in_valid(vld[3]), .in_last(in_last),
    .in_ready(ir[3]), .out_data(od3), .out_valid(ov[3]), .out_err(oe[3]), .out_ovf(oo[3]),
    .out_ready(out_ready)
  );

  typedef struct {
    int          dut;
    int          start;
    int          n;
    int          last_idx;
    logic [33:0] exp_data;
    logic        exp_err;
    logic        exp_ovf;
  } vec_t;

  vec_t        vecs [8];
  int          nvec = 0;
  logic [29:0] beats [64];
  int          nb = 0;

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [29:0] v);
    beats[nb] = v;
    nb++;
  endtask

  task automatic add_vec(input int dut, input int n, input int last_idx,
                         input logic [33:0] d, input logic e, input logic o);
    vecs[nvec] = '{dut: dut, start: nb - n, n: n, last_idx: last_idx,
                   exp_data: d, exp_err: e, exp_ovf: o};
    nvec++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat at posedge+1, confirm it is acceptable, clock it in.
  task automatic beat(input int dut, input logic [29:0] d, input logic last);
    in_data  = d;
    in_last  = last;
    vld      = '0;
    vld[dut] = 1'b1;
    #1;
    check("in_ready_beat", 34'(ir[dut]), 34'd1);
    tick();
    vld     = '0;
    in_last = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ce = 1'b1; out_ready = 1'b1; vld = '0; in_data = '0; in_last = 1'b0;

    for (int i = 0; i < 4; i++) push(30'(1000 * (i + 1)));
    add_vec(0, 4, 3, 34'd10000, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) push(30'd1073627137);
    add_vec(1, 16, 15, 34'd17178034192, 1'b0, 1'b0);
    push(30'd1073741823); push(30'd1073741823);
    add_vec(2, 2, 1, 34'd2147483646, 1'b1, 1'b0);
    push(30'd1073741823); push(30'd1073741823); push(30'd1);
    add_vec(2, 3, 2, 34'd2147483647, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push(30'd1073741823);
    add_vec(2, 4, 3, 34'd2147483647, 1'b0, 1'b1);
    push(30'd5); push(30'd6); push(30'd0); push(30'd0);
    add_vec(2, 4, 3, 34'd11, 1'b0, 1'b0);
    push(30'd7); push(30'd8);
    add_vec(0, 2, 1, 34'd15, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) push(30'd1);
    add_vec(0, 4, -1, 34'd4, 1'b1, 1'b0);

    tick(); tick();
    for (int k = 0; k < 4; k++) begin
      check("rst_in_ready", 34'(ir[k]), 34'd0);
      check("rst_out_valid", 34'(ov[k]), 34'd0);
      check("rst_out_data", od[k], 34'd0);
      check("rst_out_err", 34'(oe[k]), 34'd0);
      check("rst_out_ovf", 34'(oo[k]), 34'd0);
    end
    reset = 1'b0;
    tick();

    for (int i = 0; i < nvec; i++) begin
      for (int b = 0; b < vecs[i].n; b++) begin
        beat(vecs[i].dut, beats[vecs[i].start + b], b == vecs[i].last_idx);
        if (b < vecs[i].n - 1) check("vec_no_early_valid", 34'(ov[vecs[i].dut]), 34'd0);
      end
      check("vec_out_valid", 34'(ov[vecs[i].dut]), 34'd1);
      check("vec_out_data", od[vecs[i].dut], vecs[i].exp_data);
      check("vec_out_err", 34'(oe[vecs[i].dut]), 34'(vecs[i].exp_err));
      check("vec_out_ovf", 34'(oo[vecs[i].dut]), 34'(vecs[i].exp_ovf));
      tick();
      check("vec_valid_one_cycle", 34'(ov[vecs[i].dut]), 34'd0);
    end

    // Back-pressure on K_LEN=2
    out_ready = 1'b0;
    beat(3, 30'd1, 1'b0);
    beat(3, 30'd2, 1'b1);
    check("bp_first_valid", 34'(ov[3]), 34'd1);
    check("bp_first_data", od[3], 34'd3);
    in_data = 30'd5; vld[3] = 1'b1;
    #1;
    check("bp_in_ready_low", 34'(ir[3]), 34'd0);
    tick(); tick();
    check("bp_hold_valid", 34'(ov[3]), 34'd1);
    check("bp_hold_data", od[3], 34'd3);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_high", 34'(ir[3]), 34'd1);
    tick();
    vld = '0;
    check("bp_xfer_clears_valid", 34'(ov[3]), 34'd0);
    beat(3, 30'd6, 1'b1);
    check("bp_second_valid", 34'(ov[3]), 34'd1);
    check("bp_second_data", od[3], 34'd11);
    check("bp_second_err", 34'(oe[3]), 34'd0);
    // Transfer of 11 and a terminating beat on the same edge
    beat(3, 30'd40, 1'b1);
    check("same_cycle_valid", 34'(ov[3]), 34'd1);
    check("same_cycle_data", od[3], 34'd40);
    check("same_cycle_err", 34'(oe[3]), 34'd1);
    tick();
    check("same_cycle_drain", 34'(ov[3]), 34'd0);

    // Clock enable freeze on K_LEN=4
    beat(0, 30'd100, 1'b0);
    beat(0, 30'd200, 1'b0);
    ce = 1'b0; in_data = 30'd300; vld[0] = 1'b1;
    #1;
    check("ce_in_ready_low", 34'(ir[0]), 34'd0);
    tick(); tick(); tick();
    check("ce_no_valid", 34'(ov[0]), 34'd0);
    vld = '0; ce = 1'b1;
    beat(0, 30'd300, 1'b0);
    beat(0, 30'd400, 1'b1);
    check("ce_result_data", od[0], 34'd1000);
    check("ce_result_err", 34'(oe[0]), 34'd0);
    ce = 1'b0;
    tick(); tick(); tick();
    check("ce_hold_valid", 34'(ov[0]), 34'd1);
    check("ce_hold_data", od[0], 34'd1000);
    ce = 1'b1;
    tick();
    check("ce_release_xfer", 34'(ov[0]), 34'd0);

    // Reset mid-accumulation
    beat(0, 30'd9, 1'b0);
    beat(0, 30'd9, 1'b0);
    reset = 1'b1; in_data = 30'd9; vld[0] = 1'b1;
    #1;
    check("rst_mid_in_ready", 34'(ir[0]), 34'd0);
    tick();
    vld = '0; reset = 1'b0;
    check("rst_mid_data", od[0], 34'd0);
    check("rst_mid_valid", 34'(ov[0]), 34'd0);
    check("rst_mid_err", 34'(oe[0]), 34'd0);
    check("rst_mid_ovf", 34'(oo[0]), 34'd0);
    beat(0, 30'd1, 1'b0);
    beat(0, 30'd2, 1'b0);
    beat(0, 30'd3, 1'b0);
    check("post_rst_no_valid", 34'(ov[0]), 34'd0);
    beat(0, 30'd4, 1'b1);
    check("post_rst_valid", 34'(ov[0]), 34'd1);
    check("post_rst_data", od[0], 34'd10);
    check("post_rst_err", 34'(oe[0]), 34'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
